// File: rtl/shift_mult_ctrl_pkg.sv
// Shared types for the shift-add multiplier controller: FSM states and counter sizing.
package shift_mult_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CAP,
    S_OUT
  } state_t;

  // Step counter must reach N-1; keep at least one bit for tiny N.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_mult_ctrl_if.sv
// Operand/product handshakes plus the control/data bus to the external shift-add datapath.
interface shift_mult_ctrl_if #(
  parameter int N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_product;
  logic           busy;
  logic           mul_load;
  logic           mul_en;
  logic [N-1:0]   mul_multiplicand;
  logic [N-1:0]   mul_multiplier;
  logic [2*N-1:0] mul_product;

  modport slave (
    input  in_valid, in_a, in_b, out_ready, mul_product,
    output in_ready, out_valid, out_product, busy,
           mul_load, mul_en, mul_multiplicand, mul_multiplier
  );

  modport master (
    output in_valid, in_a, in_b, out_ready, mul_product,
    input  in_ready, out_valid, out_product, busy,
           mul_load, mul_en, mul_multiplicand, mul_multiplier
  );
endinterface

// File: rtl/shift_mult_ctrl_sign.sv
// Sign helpers for two's-complement operands; only built when SHIFT_MULT_SIGNED_EN is defined.
`ifdef SHIFT_MULT_SIGNED_EN
module shift_mult_sign #(
  parameter int N = 8
) (
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  input  logic           i_neg,
  input  logic [2*N-1:0] i_product,
  output logic [N-1:0]   o_abs_a,
  output logic [N-1:0]   o_abs_b,
  output logic [2*N-1:0] o_product
);
  // -2^(N-1) maps onto itself, which is exactly its magnitude read as unsigned.
  assign o_abs_a   = i_a[N-1] ? (~i_a + N'(1)) : i_a;
  assign o_abs_b   = i_b[N-1] ? (~i_b + N'(1)) : i_b;
  assign o_product = i_neg ? (~i_product + (2*N)'(1)) : i_product;
endmodule
`endif

// File: rtl/shift_mult_ctrl.sv
// Sequences an external shift-add datapath for N steps and holds the 2N-bit product for the consumer.
// SHIFT_MULT_SIGNED_EN enables two's-complement operands (magnitudes to the datapath, sign fixed in CAP).
module shift_mult_ctrl
  import shift_mult_ctrl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  shift_mult_ctrl_if.slave bus
);
  localparam int            CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [2*N-1:0] r_product;
  logic           r_out_valid;

  logic           w_in_ready;
  logic           w_mul_load;
  logic           w_mul_en;
  logic           w_busy;
  logic           w_accept;
  logic           w_last;
  logic [N-1:0]   w_a_op;
  logic [N-1:0]   w_b_op;
  logic [2*N-1:0] w_cap_val;

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_last   = (r_cnt == LAST);

`ifdef SHIFT_MULT_SIGNED_EN
  logic r_neg;

  shift_mult_sign #(.N(N)) u_sign (
    .i_a       (bus.in_a),
    .i_b       (bus.in_b),
    .i_neg     (r_neg),
    .i_product (bus.mul_product),
    .o_abs_a   (w_a_op),
    .o_abs_b   (w_b_op),
    .o_product (w_cap_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg <= 1'b0;
    end else if (w_accept) begin
      r_neg <= bus.in_a[N-1] ^ bus.in_b[N-1];
    end
  end
`else
  assign w_a_op    = bus.in_a;
  assign w_b_op    = bus.in_b;
  assign w_cap_val = bus.mul_product;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The datapath load follows rst so it clears together with the controller.
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_mul_load = rst;
    w_mul_en   = 1'b0;
    w_busy     = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy     = 1'b0;
        w_in_ready = !rst;
        if (bus.in_valid && !rst) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_mul_load = 1'b1;
        w_next     = S_RUN;
      end
      S_RUN: begin
        w_mul_en = !rst;
        if (w_last) begin
          w_next = S_CAP;
        end
      end
      S_CAP: begin
        w_next = S_OUT;
      end
      S_OUT: begin
        if (r_out_valid && bus.out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_product   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a <= w_a_op;
        r_b <= w_b_op;
      end
      if (r_state == S_LOAD) begin
        r_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == S_CAP) begin
        r_product   <= w_cap_val;
        r_out_valid <= 1'b1;
      end else if (r_state == S_OUT && r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready         = w_in_ready;
  assign bus.busy             = w_busy;
  assign bus.mul_load         = w_mul_load;
  assign bus.mul_en           = w_mul_en;
  assign bus.mul_multiplicand = r_a;
  assign bus.mul_multiplier   = r_b;
  assign bus.out_valid        = r_out_valid;
  assign bus.out_product      = r_product;

endmodule

// File: tb/tb_shift_mult_ctrl.sv
// Bench for shift_mult_ctrl with a behavioural shift-add datapath attached to the mul_* bus.
module tb_shift_mult_ctrl;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_mult_ctrl_if #(.N(N)) bus ();
  shift_mult_ctrl #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Datapath: load multiplier in low half, then add-and-shift-right once per enabled step.
  logic [2*N-1:0] acc;
  logic [N:0]     sum;
  assign sum = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, bus.mul_multiplicand} : {(N+1){1'b0}});
  always @(posedge clk) begin
    if (bus.mul_load) acc <= {{N{1'b0}}, bus.mul_multiplier};
    else if (bus.mul_en) acc <= {sum, acc[N-1:1]};
  end
  assign bus.mul_product = acc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] exp;
    int             hold;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    int p;
`ifdef SHIFT_MULT_SIGNED_EN
    p = int'($signed(a)) * int'($signed(b));
`else
    p = int'(a) * int'(b);
`endif
    return p[2*N-1:0];
  endfunction

  // Offer a pair and return at #1 after the accepting edge.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("accept_timeout", 32'(t < 50), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input string name, input logic [2*N-1:0] exp);
    int cycles = 0;
    int ens    = 0;
    while (!bus.out_valid && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      ens += int'(bus.mul_en);
    end
    check({name, "_latency"}, 32'(cycles), 32'(N + 2));
    check({name, "_en_cycles"}, 32'(ens), 32'(N));
    check({name, "_product"}, 32'(bus.out_product), 32'(exp));
  endtask

  task automatic drain(input int hold, input logic [2*N-1:0] exp);
    bus.out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_product", 32'(bus.out_product), 32'(exp));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("drain_valid_cleared", 32'(bus.out_valid), 32'd0);
    check("drain_idle_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    int seen;
`ifdef SHIFT_MULT_SIGNED_EN
    vecs[0] = '{8'hFD, 8'h05, 16'hFFF1, 0};
    vecs[1] = '{8'h80, 8'h80, 16'h4000, 2};
    vecs[2] = '{8'h80, 8'h01, 16'hFF80, 0};
    vecs[3] = '{8'h00, 8'hF9, 16'h0000, 1};
    vecs[4] = '{8'hFF, 8'hFF, 16'h0001, 0};
    vecs[5] = '{8'h7F, 8'h7F, 16'h3F01, 3};
`else
    vecs[0] = '{8'd13,  8'd11,  16'h008F, 0};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01, 2};
    vecs[2] = '{8'd0,   8'd200, 16'h0000, 0};
    vecs[3] = '{8'd7,   8'd9,   16'h003F, 1};
    vecs[4] = '{8'd128, 8'd2,   16'h0100, 0};
    vecs[5] = '{8'd1,   8'd255, 16'h00FF, 3};
`endif
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_product", 32'(bus.out_product), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_mul_en", 32'(bus.mul_en), 32'd0);
    check("rst_mul_load", 32'(bus.mul_load), 32'd1);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_mul_load", 32'(bus.mul_load), 32'd0);

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].a, vecs[i].b);
      check("load_after_accept", 32'(bus.mul_load), 32'd1);
      collect("vec", vecs[i].exp);
      drain(vecs[i].hold, vecs[i].exp);
    end

    // Backpressure with a second pair waiting on the input side.
    send(8'd13, 8'd11);
    collect("bp_first", ref_mul(8'd13, 8'd11));
    bus.in_valid = 1'b1;
    bus.in_a     = 8'd3;
    bus.in_b     = 8'd5;
    drain(5, ref_mul(8'd13, 8'd11));
    send(8'd3, 8'd5);
    collect("bp_second", ref_mul(8'd3, 8'd5));
    drain(0, ref_mul(8'd3, 8'd5));

    // Reset in the middle of RUN discards the product.
    send(8'd13, 8'd11);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("midrun_mul_en", 32'(bus.mul_en), 32'd1);
    rst = 1'b1;
    #1;
    check("midrun_rst_mul_load", 32'(bus.mul_load), 32'd1);
    check("midrun_rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrun_idle_busy", 32'(bus.busy), 32'd0);
    check("midrun_idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrun_no_valid", 32'(bus.out_valid), 32'd0);
    check("midrun_product_cleared", 32'(bus.out_product), 32'd0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1;
    end
    check("midrun_discarded", 32'(seen), 32'd0);
    send(8'd7, 8'd9);
    collect("after_rst", ref_mul(8'd7, 8'd9));
    drain(0, ref_mul(8'd7, 8'd9));

    // Random operands against plain arithmetic.
    for (int i = 0; i < 30; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      send(ra, rb);
      collect("rand", ref_mul(ra, rb));
      drain(int'($urandom_range(0, 3)), ref_mul(ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_mult_ctrl.md
# shift_mult_ctrl

Sequencing front end for the shift-add multiplier datapath. Accepts operand pairs over a valid/ready handshake and drives the datapath's load and step-enable for exactly N steps. Captures the 2N-bit product into a held output register presented over a second valid/ready handshake. Sits directly upstream of the datapath and consumes its product bus; the datapath itself is external and connected through the `mul_*` ports.

## Interface
- `N`, 8, operand width in bits; N >= 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept an operand pair.
- `in_a`  in  N  multiplicand.
- `in_b`  in  N  multiplier.
- `out_valid`  out  1  `out_product` valid.
- `out_ready`  in  1  consumer takes the product.
- `out_product`  out  2N  registered product.
- `busy`  out  1  high in every state except IDLE.
- `mul_load`  out  1  datapath load/clear; loads `mul_multiplier` and zeroes the upper half.
- `mul_en`  out  1  datapath step enable.
- `mul_multiplicand`  out  N  held multiplicand to the datapath.
- `mul_multiplier`  out  N  held multiplier to the datapath.
- `mul_product`  in  2N  datapath product bus.

## Operation
- FSM states: IDLE, LOAD, RUN, CAP, OUT.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, register `in_a` and `in_b` into the operand registers, then go to LOAD.
- LOAD: `mul_load`=1 for one cycle, then go to RUN with the step counter cleared.
- RUN: `mul_en`=1. The counter increments each cycle. When counter==N-1, go to CAP, so `mul_en` is high for exactly N cycles.
- CAP: register `mul_product` into `out_product`, set `out_valid`, go to OUT.
- OUT: hold `out_product`/`out_valid` stable until `out_valid && out_ready`, then clear `out_valid` and go to IDLE.
- `in_ready` is 0 in every state except IDLE. An input offered during OUT waits; there is no skid buffer.
- `mul_multiplicand`/`mul_multiplier` always equal the operand registers and stay stable from LOAD through CAP.
- Counter width is $clog2(N). All arithmetic is unsigned modulo 2^(2N) unless the macro below is defined.

## Timing
- Accept at edge E0. LOAD occupies E0–E1. RUN occupies E1–E(N+1). CAP occupies E(N+1)–E(N+2). `out_valid` rises after E(N+2).
- Accept-to-`out_valid` latency is N+2 cycles.
- Minimum issue interval is N+4 cycles (OUT accepted on its first cycle, then one IDLE cycle).
- Reset values: `in_ready`=0 while `rst` is high, then 1 after reset. `out_valid`=0, `out_product`=0, `busy`=0, `mul_en`=0.
- `mul_load` = `rst` OR (state==LOAD), so the datapath clears with the controller.
- `rst` in any state, including mid-RUN or OUT: next state is IDLE, the counter clears, and any pending product is discarded with no `out_valid`.
- `out_ready` high while `out_valid`=0 has no effect.

## Configuration
- `SHIFT_MULT_SIGNED_EN` defined: operands are two's complement.
  - At accept, the operand registers store |in_a| and |in_b| as N-bit unsigned; |-2^(N-1)| = 2^(N-1) fits.
  - The sign bit `in_a[N-1]^in_b[N-1]` is registered.
  - In CAP, the product is two's-complement negated in 2N bits when the sign bit is 1; zero stays zero.
  - Latency is unchanged.
- Undefined: pure unsigned operation; no sign register or negation logic is present.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE, LOAD, RUN, CAP, OUT);
  - a function computing counter width from N.
- One natural sub-module: `shift_mult_sign`, compiled only under `SHIFT_MULT_SIGNED_EN`.
  - Provides operand absolute value.
  - Provides conditional 2N-bit negation.
- The FSM and counter stay in the top module.

## Test plan
All cases use N=8 with the datapath connected unless noted.
- Unsigned 13×11: accept at E0 → `out_valid` after E10, `out_product`=16'h008F, `mul_en` high exactly 8 cycles.
- 255×255 → 16'hFE01; 0×200 → 16'h0000.
- Backpressure: `out_ready` low 5 cycles after `out_valid` → product and `out_valid` stable.
  - `in_ready`=0 throughout; a second pair offered is accepted only once IDLE is re-entered.
- `rst` asserted for one cycle at RUN step 4 → IDLE next cycle, no `out_valid`, `mul_load` high during reset.
  - A subsequent 7×9 yields 16'h003F.
- Signed (macro defined):
  - −3×5 → 16'hFFF1.
  - −128×−128 → 16'h4000.
  - −128×1 → 16'hFF80.
  - 0×−7 → 16'h0000.
